// File: rtl/hilo_pkg.sv
// Shared definitions for the HI/LO register block: op encodings and op width.
package hilo_pkg;

   localparam int HILO_OP_W = 3;

   typedef enum logic [HILO_OP_W-1:0] {
      HILO_WR_BOTH = 3'd0,
      HILO_WR_HI   = 3'd1,
      HILO_WR_LO   = 3'd2,
      HILO_ACC_ADD = 3'd3,
      HILO_ACC_SUB = 3'd4
   } hilo_op_e;

endpackage

// File: rtl/hilo_acc_pipe.sv
// Accumulate stage for hilo_acc_reg: captures a 2*DATA_W product and the
// add/sub selector, then presents {HI,LO} +/- P one cycle later.
// Only instantiated when HILO_ACC_EN is defined.
module hilo_acc_pipe #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              flush,
   input  logic              start,
   input  logic              sub,
   input  logic [2*DATA_W-1:0] p_i,
   input  logic [2*DATA_W-1:0] hilo_i,
   output logic              busy,
   output logic              upd_valid,
   output logic [2*DATA_W-1:0] sum_o
);

   logic                valid_q, valid_d;
   logic                sub_q, sub_d;
   logic [2*DATA_W-1:0] p_q, p_d;

   // Next-state for the stage: load on start, otherwise hold data and drop valid.
   always_comb begin
      // NOTE: every output gets a default first so no latch is inferred.
      valid_d = start;
      sub_d   = sub_q;
      p_d     = p_q;
      if (start) begin
         sub_d = sub;
         p_d   = p_i;
      end
   end

   // Stage register; the data flops are reset too so reset leaves no stale product.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         // NOTE: sequential state uses non-blocking assignments only.
         valid_q <= 1'b0;
         sub_q   <= 1'b0;
         p_q     <= '0;
      end else begin
         valid_q <= valid_d;
         sub_q   <= sub_d;
         p_q     <= p_d;
      end
   end

   // The add/sub wraps modulo 2^(2*DATA_W); carry/borrow crosses LO into HI naturally.
   always_comb begin
      sum_o = sub_q ? (hilo_i - p_q) : (hilo_i + p_q);
   end

   assign busy      = valid_q;
   assign upd_valid = valid_q && !flush;

endmodule

// File: rtl/hilo_acc_reg.sv
// Architectural HI/LO register pair with whole/half writes and an optional
// two-cycle accumulate (MADD/MSUB class). The accumulate path is present only
// when the macro HILO_ACC_EN is defined; otherwise ops 3/4 act as reserved
// and busy is tied low.
module hilo_acc_reg
   import hilo_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic                 flush,
   input  logic                 op_valid,
   input  logic [HILO_OP_W-1:0] op,
   input  logic [DATA_W-1:0]    hi_i,
   input  logic [DATA_W-1:0]    lo_i,
   output logic                 busy,
   output logic [DATA_W-1:0]    hi_o,
   output logic [DATA_W-1:0]    lo_o
);

   logic [DATA_W-1:0] hi_q, hi_d;
   logic [DATA_W-1:0] lo_q, lo_d;
   logic              accept;

   // A request only takes effect when nothing is in flight and no flush is present.
   assign accept = op_valid && !busy && !flush;

`ifdef HILO_ACC_EN
   logic                acc_start;
   logic                acc_sub;
   logic                acc_upd;
   logic [2*DATA_W-1:0] acc_sum;

   hilo_acc_pipe #(.DATA_W(DATA_W)) u_acc_pipe (
      .clk       (clk),
      .resetn    (resetn),
      .flush     (flush),
      .start     (acc_start),
      .sub       (acc_sub),
      .p_i       ({hi_i, lo_i}),
      .hilo_i    ({hi_q, lo_q}),
      .busy      (busy),
      .upd_valid (acc_upd),
      .sum_o     (acc_sum)
   );
`else
   assign busy = 1'b0;
`endif

   // Next HI/LO: accumulate result (only possible while busy) or an accepted write.
   always_comb begin
      hi_d = hi_q;
      lo_d = lo_q;
`ifdef HILO_ACC_EN
      acc_start = 1'b0;
      acc_sub   = 1'b0;
      if (acc_upd) begin
         {hi_d, lo_d} = acc_sum;
      end else
`endif
      if (accept) begin
         case (op)
            HILO_WR_BOTH: begin
               hi_d = hi_i;
               lo_d = lo_i;
            end
            HILO_WR_HI: hi_d = hi_i;
            HILO_WR_LO: lo_d = lo_i;
`ifdef HILO_ACC_EN
            HILO_ACC_ADD: acc_start = 1'b1;
            HILO_ACC_SUB: begin
               acc_start = 1'b1;
               acc_sub   = 1'b1;
            end
`endif
            default: ;
         endcase
      end
   end

   // Architectural HI/LO registers.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         hi_q <= '0;
         lo_q <= '0;
      end else begin
         hi_q <= hi_d;
         lo_q <= lo_d;
      end
   end

   assign hi_o = hi_q;
   assign lo_o = lo_q;

endmodule

// File: tb/tb_hilo_acc_reg.sv
// Self-checking bench for hilo_acc_reg. A behavioural model predicts HI/LO/busy
// for every cycle; predictions are pushed to a queue at the clock edge and
// popped and compared once the DUT outputs have settled. Expectations follow
// whichever build HILO_ACC_EN selects.
module tb_hilo_acc_reg;
   import hilo_pkg::*;

   localparam int W = 32;

`ifdef HILO_ACC_EN
   localparam bit ACC_EN = 1'b1;
`else
   localparam bit ACC_EN = 1'b0;
`endif

   typedef struct packed {
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      logic         busy;
   } exp_t;

   logic                 clk = 1'b0;
   logic                 resetn = 1'b0;
   logic                 flush = 1'b0;
   logic                 op_valid = 1'b0;
   logic [HILO_OP_W-1:0] op = '0;
   logic [W-1:0]         hi_i = '0;
   logic [W-1:0]         lo_i = '0;
   logic                 busy;
   logic [W-1:0]         hi_o;
   logic [W-1:0]         lo_o;

   int n_vec  = 0;
   int n_miss = 0;

   // Model state
   logic [W-1:0]   m_hi = '0;
   logic [W-1:0]   m_lo = '0;
   logic           m_busy = 1'b0;
   logic           m_sub = 1'b0;
   logic [2*W-1:0] m_p = '0;
   exp_t           sb_q[$];

   hilo_acc_reg #(.DATA_W(W)) dut (
      .clk      (clk),
      .resetn   (resetn),
      .flush    (flush),
      .op_valid (op_valid),
      .op       (op),
      .hi_i     (hi_i),
      .lo_i     (lo_i),
      .busy     (busy),
      .hi_o     (hi_o),
      .lo_o     (lo_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", tag, act, exp);
      end
   endtask

   // Compare all three outputs against the oldest scoreboard entry.
   task automatic pop_check(input string tag);
      exp_t e;
      if (sb_q.size() == 0) begin
         check({tag, "_sb_empty"}, 32'd1, 32'd0);
         return;
      end
      e = sb_q.pop_front();
      check({tag, "_hi"},   hi_o, e.hi);
      check({tag, "_lo"},   lo_o, e.lo);
      check({tag, "_busy"}, {31'd0, busy}, {31'd0, e.busy});
   endtask

   // One clock of the model, evaluated with the inputs present at the edge.
   task automatic model_edge();
      logic [2*W-1:0] cur;
      logic           acc_ok;
      cur    = {m_hi, m_lo};
      acc_ok = op_valid && !m_busy && !flush;
      if (m_busy) begin
         if (!flush) {m_hi, m_lo} = m_sub ? cur - m_p : cur + m_p;
         m_busy = 1'b0;
      end else if (acc_ok) begin
         case (op)
            3'd0: begin m_hi = hi_i; m_lo = lo_i; end
            3'd1: m_hi = hi_i;
            3'd2: m_lo = lo_i;
            3'd3, 3'd4: if (ACC_EN) begin
               m_busy = 1'b1;
               m_sub  = (op == 3'd4);
               m_p    = {hi_i, lo_i};
            end
            default: ;
         endcase
      end
   endtask

   // Drive one cycle of stimulus at the falling edge, confirm nothing changes
   // combinationally, then let the edge happen and score the result.
   task automatic cycle(input string tag, input logic v, input logic [2:0] o,
                        input logic [W-1:0] h, input logic [W-1:0] l, input logic f);
      @(negedge clk);
      op_valid = v; op = o; hi_i = h; lo_i = l; flush = f;
      #1;
      check({tag, "_pre_hi"}, hi_o, m_hi);
      check({tag, "_pre_lo"}, lo_o, m_lo);
      @(posedge clk);
      model_edge();
      sb_q.push_back('{hi: m_hi, lo: m_lo, busy: m_busy});
      #1;
      pop_check(tag);
   endtask

   task automatic idle(input string tag);
      cycle(tag, 1'b0, 3'd0, '0, '0, 1'b0);
   endtask

   task automatic model_reset();
      m_hi = '0; m_lo = '0; m_busy = 1'b0; m_sub = 1'b0; m_p = '0;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      @(negedge clk);
      resetn = 1'b1;
      #1;
      sb_q.push_back('{hi: '0, lo: '0, busy: 1'b0});
      pop_check("reset");

      // Whole and half writes
      cycle("wr_both", 1'b1, 3'd0, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
      cycle("wr_lo",   1'b1, 3'd2, 32'hDEAD_BEEF, 32'h0000_0001, 1'b0);
      cycle("wr_hi",   1'b1, 3'd1, 32'h0BAD_F00D, 32'hFFFF_FFFF, 1'b0);

      // Carry from LO into HI
      cycle("cy_set", 1'b1, 3'd0, 32'h0, 32'hFFFF_FFFF, 1'b0);
      cycle("cy_acc", 1'b1, 3'd3, 32'h0, 32'h1, 1'b0);
      idle("cy_done");

      // Borrow and wrap
      cycle("bw_set", 1'b1, 3'd0, 32'h0, 32'h0, 1'b0);
      cycle("bw_acc", 1'b1, 3'd4, 32'h0, 32'h1, 1'b0);
      idle("bw_done");

      // Busy backpressure: the write is held and retried
      cycle("bp_acc", 1'b1, 3'd3, 32'h0, 32'h1, 1'b0);
      cycle("bp_wr0", 1'b1, 3'd0, 32'hAAAA_AAAA, 32'h5555_5555, 1'b0);
      cycle("bp_wr1", 1'b1, 3'd0, 32'hAAAA_AAAA, 32'h5555_5555, 1'b0);
      idle("bp_done");

      // Flush in the busy cycle
      cycle("fl_set", 1'b1, 3'd0, 32'h10, 32'h10, 1'b0);
      cycle("fl_acc", 1'b1, 3'd3, 32'h0, 32'h5, 1'b0);
      cycle("fl_kill", 1'b0, 3'd0, 32'h0, 32'h0, 1'b1);
      idle("fl_done");

      // Flush together with a valid op drops the op
      cycle("fl_drop", 1'b1, 3'd0, 32'h7777_7777, 32'h8888_8888, 1'b1);

      // Reserved ops do nothing
      cycle("rsv5", 1'b1, 3'd5, 32'h1111_1111, 32'h2222_2222, 1'b0);
      cycle("rsv7", 1'b1, 3'd7, 32'h3333_3333, 32'h4444_4444, 1'b0);

      // Asynchronous reset while an accumulate is in flight
      cycle("ar_set", 1'b1, 3'd0, 32'h1, 32'h2, 1'b0);
      cycle("ar_acc", 1'b1, 3'd3, 32'h0, 32'h1, 1'b0);
      @(negedge clk);
      op_valid = 1'b0; flush = 1'b0;
      #2;
      resetn = 1'b0;
      #1;
      model_reset();
      sb_q.push_back('{hi: '0, lo: '0, busy: 1'b0});
      pop_check("ar_now");
      @(posedge clk);
      @(negedge clk);
      resetn = 1'b1;
      idle("ar_after");

      // Mixed random traffic against the model
      for (int i = 0; i < 40; i++) begin
         cycle("rnd", ($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
               $urandom, $urandom, ($urandom_range(0, 7) == 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/hilo_acc_reg.md
# hilo_acc_reg

Parametrised successor to the CPU's HI/LO register pair. Holds the architectural HI and LO registers, written whole or per half for MTHI/MTLO/MULT/DIV results. Also performs a two-cycle accumulate (MADD/MSUB-class) of a 2×DATA_W product into {HI,LO}, with a busy handshake toward the pipeline. Sits in the write-back side of the MIPS core, fed by the multiply/divide unit and the MT* path.

## Interface
Parameters:
- DATA_W, 32, width of each of HI and LO.

Ports:
- clk  in  1  sole clock, all state on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- flush  in  1  kills any accumulate in flight and any op presented this cycle.
- op_valid  in  1  request valid.
- op  in  3  0=WR_BOTH, 1=WR_HI, 2=WR_LO, 3=ACC_ADD, 4=ACC_SUB, 5–7 reserved (no effect).
- hi_i  in  DATA_W  write data for HI, or upper half of the product for ACC.
- lo_i  in  DATA_W  write data for LO, or lower half of the product for ACC.
- busy  out  1  accumulate in flight; requests are not accepted while high.
- hi_o  out  DATA_W  architectural HI.
- lo_o  out  DATA_W  architectural LO.

## Operation
- Accept condition: op_valid && !busy && !flush. If the request is not accepted, it has no effect. The caller must hold it; nothing is queued.
- WR_BOTH: hi_o<=hi_i and lo_o<=lo_i.
- WR_HI: updates only HI.
- WR_LO: updates only LO.
- ACC_ADD/ACC_SUB: stage register captures {hi_i,lo_i} as a 2×DATA_W value P and the op.
  - Next cycle: {hi_o,lo_o} <= {hi_o,lo_o} ± P, computed modulo 2^(2×DATA_W).
  - Carry/borrow crosses from LO into HI. No overflow detection.
  - Signed versus unsigned variants are resolved upstream by how the product is extended. This block is sign-agnostic.
- busy equals the stage-valid flag. It is high exactly one cycle per accepted accumulate.
- flush while busy: clears the stage. HI/LO are not modified, and busy drops next cycle.
- Reserved ops, if accepted: no state change, and busy is not set.
- Reset (async, any time including mid-accumulate): hi_o=0, lo_o=0, busy=0, stage cleared.

## Timing
- Write ops: result visible on hi_o/lo_o the cycle after the accepting edge (1-cycle latency). No combinational bypass from inputs to outputs.
- Accumulate:
  - Accepted at edge N.
  - busy high in cycle N..N+1.
  - {HI,LO} updated at edge N+1.
  - busy low after N+1.
  - A new op can be accepted at edge N+2.
- Back-to-back writes: one per cycle. Back-to-back accumulates: one every 2 cycles.
- Accumulate operand for HI/LO is the registered value at edge N+1. Any write accepted earlier is therefore included.
- flush and op_valid in the same cycle: the op is dropped, and any in-flight stage is cleared.

## Configuration
- HILO_ACC_EN defined: accumulate path, stage register and busy logic are present, as described above.
- HILO_ACC_EN undefined:
  - ops 3 and 4 behave as reserved (no effect).
  - busy is tied 0.
  - No stage register or 2×DATA_W adder is synthesised.
  - Write ops are unchanged.

## Structure
- Shared package hilo_pkg holds:
  - op encodings HILO_WR_BOTH, HILO_WR_HI, HILO_WR_LO, HILO_ACC_ADD, HILO_ACC_SUB.
  - op width constant HILO_OP_W=3.
- One sub-module, hilo_acc_pipe: the stage register plus the 2×DATA_W add/sub. It is instantiated only under HILO_ACC_EN.
- The top keeps the HI/LO registers and the accept/flush logic.

## Test plan
- Reset and writes: release reset, then WR_BOTH hi_i=0x12345678, lo_i=0x9ABCDEF0.
  - Required: outputs are 0/0 before the accepting edge and 0x12345678/0x9ABCDEF0 after it.
  - Then WR_LO 0x1 → HI unchanged, LO=0x00000001.
- Carry across halves: HI=0, LO=0xFFFFFFFF, then ACC_ADD P=0x0000_0000_0000_0001.
  - Required: busy high 1 cycle, then HI=0x00000001, LO=0x00000000.
- Borrow and wrap: HI=LO=0, then ACC_SUB P=1.
  - Required: HI=LO=0xFFFFFFFF.
- Busy backpressure: ACC_ADD accepted, with WR_BOTH 0xAAAA_AAAA/0x5555_5555 held valid the next cycle.
  - Required: the write is ignored while busy and accepted the following cycle; final outputs are 0xAAAAAAAA/0x55555555.
- Flush mid-accumulate: HI=LO=0x10, ACC_ADD P=5, flush asserted in the busy cycle.
  - Required: HI=LO=0x10 unchanged and busy low next cycle.
- Async reset mid-accumulate: assert resetn=0 between clock edges while busy.
  - Required: hi_o=lo_o=0 and busy=0 immediately, without waiting for a clock edge.
  - Build without HILO_ACC_EN: ACC_ADD P=1 → no change, busy never high.
